// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit-trace buffer.
// With COMMIT_TRACE_TIMESTAMP_EN defined, records also carry a 32-bit cycle stamp.
package commit_trace_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int ILEN_DEF   = 32;
  localparam int SEQ_W_DEF  = 16;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [ILEN_DEF-1:0]  instr;
    logic [XLEN_DEF-1:0]  pc;
    logic [XLEN_DEF-1:0]  pre_pc;
    logic [SEQ_W_DEF-1:0] seq;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0]          cycle;
`endif
  } commit_rec_t;

  localparam int COMMIT_REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/commit_trace_fifo_mem.sv
// Record storage: DEPTH x W register array, one synchronous write port and an
// asynchronous read port so the FIFO head is visible in the cycle after its push.
module commit_trace_fifo_mem
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = COMMIT_REC_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Entries clear on reset so the head fields read as zero until the first push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit-trace FIFO: sequence-numbers retired instructions, drops on overflow,
// and requests a pipeline stall near full. Optional COMMIT_TRACE_TIMESTAMP_EN adds trace_cycle.
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int ILEN         = 32,
  parameter int DEPTH        = 8,
  parameter int SEQ_W        = 16,
  parameter int STALL_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit,
  input  logic [ILEN-1:0]         commit_instr,
  input  logic [XLEN-1:0]         commit_pc,
  input  logic [XLEN-1:0]         commit_pre_pc,
  input  logic                    flush,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [ILEN-1:0]         trace_instr,
  output logic [XLEN-1:0]         trace_pc,
  output logic [XLEN-1:0]         trace_pre_pc,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    stall_req,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]             trace_cycle
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - STALL_MARGIN);

  typedef struct packed {
    logic [ILEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pre_pc;
    logic [SEQ_W-1:0] seq;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0]      cycle;
`endif
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic                  stall_q, stall_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  valid_s, full_s, pop_s, push_s, drop_s;
  rec_t                  wr_rec_s, rd_rec_s;
  logic [REC_W-1:0]      wr_data_s, rd_data_s;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] cycle_q;

  // Free-running cycle stamp; flush leaves it running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end
`endif

  // Handshake decode; flush masks both push and pop.
  always_comb begin
    valid_s = (count_q != '0);
    full_s  = (count_q == FULL_CNT);
    pop_s   = valid_s && trace_ready && !flush;
    push_s  = commit && !flush && (!full_s || pop_s);
    drop_s  = commit && !flush && full_s && !pop_s;
  end

  // Record assembly for the write port.
  always_comb begin
    wr_rec_s        = '0;
    wr_rec_s.instr  = commit_instr;
    wr_rec_s.pc     = commit_pc;
    wr_rec_s.pre_pc = commit_pre_pc;
    wr_rec_s.seq    = seq_q;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    wr_rec_s.cycle  = cycle_q;
`endif
    wr_data_s       = wr_rec_s;
    rd_rec_s        = rec_t'(rd_data_s);
  end

  // Next-state for pointers, occupancy, sequence and error tracking.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      wr_ptr_d   = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // Dropped commits still consume a sequence value so the host sees a gap.
      seq_d      = commit ? seq_q + SEQ_W'(1) : seq_q;
      overflow_d = overflow_q | drop_s;
      if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
    stall_d = (count_d >= STALL_TH);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  commit_trace_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  assign trace_valid  = valid_s;
  assign trace_instr  = rd_rec_s.instr;
  assign trace_pc     = rd_rec_s.pc;
  assign trace_pre_pc = rd_rec_s.pre_pc;
  assign trace_seq    = rd_rec_s.seq;
  assign count        = count_q;
  assign stall_req    = stall_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign trace_cycle  = rd_rec_s.cycle;
`endif

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo (DEPTH=8, STALL_MARGIN=2, SEQ_W=4) with a
// record scoreboard queue and a small behavioural model of occupancy and errors.
module tb_commit_trace_fifo;

  logic        clk;
  logic        rst;
  logic        commit;
  logic [31:0] commit_instr;
  logic [63:0] commit_pc;
  logic [63:0] commit_pre_pc;
  logic        flush;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_instr;
  logic [63:0] trace_pc;
  logic [63:0] trace_pre_pc;
  logic [3:0]  trace_seq;
  logic [3:0]  count;
  logic        stall_req;
  logic        overflow;
  logic [15:0] drop_cnt;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] trace_cycle;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pre_pc;
    logic [3:0]  seq;
  } rec_t;

  rec_t        q[$];
  logic [3:0]  seq_m;
  logic        ovf_m;
  logic [15:0] drop_m;
  logic [3:0]  last_seq;
  int          errors = 0;
  int          checks = 0;

  commit_trace_fifo #(
    .XLEN(64), .ILEN(32), .DEPTH(8), .SEQ_W(4), .STALL_MARGIN(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .commit        (commit),
    .commit_instr  (commit_instr),
    .commit_pc     (commit_pc),
    .commit_pre_pc (commit_pre_pc),
    .flush         (flush),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_instr   (trace_instr),
    .trace_pc      (trace_pc),
    .trace_pre_pc  (trace_pre_pc),
    .trace_seq     (trace_seq),
    .count         (count),
    .stall_req     (stall_req),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    ,
    .trace_cycle   (trace_cycle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; commit = 1'b0; flush = 1'b0; trace_ready = 1'b0;
    commit_instr = 32'd0; commit_pc = 64'd0; commit_pre_pc = 64'd0;
    #2;
    chk("rst_valid", trace_valid, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_pc", trace_pc, 64'd0);
    chk("rst_seq", trace_seq, 4'd0);
    q.delete(); seq_m = 4'd0; ovf_m = 1'b0; drop_m = 16'd0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock: drive inputs, check the head against the scoreboard, update the model, check state after the edge.
  task automatic cyc(input logic c, input logic [63:0] pc, input logic rdy, input logic fl);
    logic full_m, pop_m;
    rec_t r;
    commit = c; commit_pc = pc; commit_instr = pc[31:0] ^ 32'h0000_0013;
    commit_pre_pc = pc + 64'd4; trace_ready = rdy; flush = fl;
    full_m = (q.size() == 8);
    pop_m  = (q.size() != 0) && rdy && !fl;
    if (q.size() != 0) begin
      chk("head_seq", trace_seq, q[0].seq);
      chk("head_pc", trace_pc, q[0].pc);
      chk("head_instr", trace_instr, q[0].instr);
      chk("head_prepc", trace_pre_pc, q[0].pre_pc);
    end
    if (pop_m) begin
      last_seq = trace_seq;
      r = q.pop_front();
    end
    if (fl) begin
      q.delete(); ovf_m = 1'b0; drop_m = 16'd0;
    end else if (c) begin
      if (!full_m || pop_m) begin
        r.instr = pc[31:0] ^ 32'h0000_0013; r.pc = pc; r.pre_pc = pc + 64'd4; r.seq = seq_m;
        q.push_back(r);
      end else begin
        ovf_m = 1'b1;
        if (drop_m != 16'hffff) drop_m = drop_m + 16'd1;
      end
      seq_m = seq_m + 4'd1;
    end
    @(posedge clk); #1;
    commit = 1'b0; trace_ready = 1'b0; flush = 1'b0;
    chk("count", count, q.size());
    chk("valid", trace_valid, q.size() != 0);
    chk("ovf", overflow, ovf_m);
    chk("drop", drop_cnt, drop_m);
    chk("stall", stall_req, q.size() >= 6);
  endtask

  initial begin
    last_seq = 4'd0;
    do_reset();

    // In-order exit with seq 0,1,2; valid falls after the last pop.
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0);
    chk("t1_last_seq", last_seq, 4'd2);
    chk("t1_valid_low", trace_valid, 1'b0);

    // Stall threshold, fill, and drop.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
    chk("t2_stall_5", stall_req, 1'b0);
    cyc(1'b1, 64'h8000_0014, 1'b0, 1'b0);
    chk("t2_stall_6", stall_req, 1'b1);
    chk("t2_count_6", count, 4'd6);
    for (int i = 6; i < 8; i++) cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
    cyc(1'b1, 64'h8000_0100, 1'b0, 1'b0);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_drop", drop_cnt, 16'd1);
    chk("t3_count", count, 4'd8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0);
    chk("t3_drain_last", last_seq, 4'd7);
    cyc(1'b1, 64'h8000_0200, 1'b0, 1'b0);
    chk("t3_next_seq", trace_seq, 4'd9);
    cyc(1'b0, 64'd0, 1'b1, 1'b0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'h8000_0300 + 64'(4 * i), 1'b0, 1'b0);
    cyc(1'b1, 64'h8000_0400, 1'b1, 1'b0);
    chk("t4_count", count, 4'd8);
    chk("t4_head_seq", trace_seq, 4'd11);
    chk("t4_drop", drop_cnt, 16'd1);

    // Flush at count=5 with overflow set and a concurrent commit.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0);
    chk("t5_count_5", count, 4'd5);
    cyc(1'b1, 64'h8000_0500, 1'b1, 1'b1);
    chk("t5_count", count, 4'd0);
    chk("t5_valid", trace_valid, 1'b0);
    chk("t5_ovf", overflow, 1'b0);
    cyc(1'b1, 64'h8000_0600, 1'b0, 1'b0);
    chk("t5_seq", trace_seq, 4'd9);
    chk("t5_pc", trace_pc, 64'h8000_0600);

    // Sequence wrap with SEQ_W=4.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 64'h8000_1000 + 64'(4 * i), 1'b1, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0);
    chk("t6_wrap_seq", last_seq, 4'd0);

    // Asynchronous reset mid-operation, away from any clock edge.
    for (int i = 0; i < 7; i++) cyc(1'b1, 64'h8000_2000 + 64'(4 * i), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 4'd0);
    chk("arst_valid", trace_valid, 1'b0);
    chk("arst_stall", stall_req, 1'b0);
    chk("arst_ovf", overflow, 1'b0);
    do_reset();
    cyc(1'b1, 64'h8000_3000, 1'b0, 1'b0);
    chk("arst_seq0", trace_seq, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
